// File: rtl/alu_seq_unit.sv
// Sequential N-bit ALU: single-cycle AND/OR/ADD/SLT with b-invert and group flags,
// plus iterative shifts (one bit per cycle) and shift-add multiply behind a valid/ready handshake.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             g,
    output logic             p,
    output logic             set,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mop_q, mop_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             g_q, g_d;
    logic             p_q, p_d;
    logic             set_q, set_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] b_eff;
    logic             ci;
    logic [WIDTH:0]   gen_sum;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             slt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] step_res;
    logic             accept;

    // Single-cycle datapath; the carry-in-0 sum gives g and is reused for the full add.
    always_comb begin
        b_eff   = op[2] ? ~b : b;
        ci      = op[2] | cin;
        gen_sum = (WIDTH+1)'(a) + (WIDTH+1)'(b_eff);
        add_sum = gen_sum[WIDTH-1:0] + WIDTH'(ci);
        add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
        slt     = $signed(a) < $signed(b);
        case (op[1:0])
            2'b00:   sc_res = a & b_eff;
            2'b01:   sc_res = a | b_eff;
            2'b10:   sc_res = add_sum;
            default: sc_res = WIDTH'(slt);
        endcase
    end

    // One iteration of the active multi-cycle op; SRA refills from the retained sign bit.
    always_comb begin
        case (mop_q)
            2'b00:   shift_a = a_q << 1;
            2'b01:   shift_a = a_q >> 1;
            default: shift_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        endcase
        mul_acc  = b_q[0] ? (acc_q + a_q) : acc_q;
        step_res = (mop_q == 2'b11) ? mul_acc : shift_a;
    end

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mop_d    = mop_q;
        result_d = result_q;
        g_d      = g_q;
        p_d      = p_q;
        set_d    = set_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (mop_q == 2'b11) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    a_d = shift_a;
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = step_res;
                    zero_d   = (step_res == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance overrides the DONE->IDLE drain so a new op can follow without a bubble.
        if (accept) begin
            a_d   = a;
            b_d   = b;
            mop_d = op[1:0];
            acc_d = '0;
            cnt_d = '0;
            g_d   = 1'b0;
            p_d   = 1'b0;
            set_d = 1'b0;
            ovf_d = 1'b0;
            if (!op[3]) begin
                state_d  = S_DONE;
                result_d = sc_res;
                zero_d   = (sc_res == '0);
                g_d      = gen_sum[WIDTH];
                p_d      = &(a | b_eff);
                set_d    = slt;
                ovf_d    = add_ovf;
            end else if (op[2]) begin
                state_d  = S_DONE;
                result_d = '0;
                zero_d   = 1'b1;
            end else if (op[1:0] == 2'b11) begin
                state_d = S_BUSY;
                cnt_d   = CW'(WIDTH);
            end else if (b[SHW-1:0] == '0) begin
                state_d  = S_DONE;
                result_d = a;
                zero_d   = (a == '0);
            end else begin
                state_d = S_BUSY;
                cnt_d   = CW'(b[SHW-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mop_q    <= '0;
            result_q <= '0;
            g_q      <= 1'b0;
            p_q      <= 1'b0;
            set_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mop_q    <= mop_d;
            result_q <= result_d;
            g_q      <= g_d;
            p_q      <= p_d;
            set_q    <= set_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign g         = g_q;
    assign p         = p_q;
    assign set       = set_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised N-bit successor to the one-bit ALU slice. Keeps the slice's AND/OR/ADD/SLT core with b-invert and its group g/p/set outputs.
- Adds registered outputs, a valid/ready handshake and multi-cycle iterative ops: shifts at one bit per cycle and a shift-add multiply.
- Sits between operand fetch and writeback in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2, minimum 4.
- SHW, $clog2(WIDTH), local parameter; number of shift-amount bits taken from b.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount.
- cin  input  1  carry-in for ADD only.
- op  input  4  operation code.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- g  output  1  group generate.
- p  output  1  group propagate.
- set  output  1  signed a<b.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Opcodes: op[3]=0 is the single-cycle class. op[2]=binvert, so b' = op[2] ? ~b : b.
  - op[1:0]: 00 AND a&b'; 01 OR a|b'; 10 ADD a+b'+ci; 11 SLT, result = {0…,set}.
  - ci = op[2] ? 1 : cin. So 0110 = SUB and cin is ignored for it.
  - SLT (0011 and 0111) always evaluates a-b, independent of op[2].
- Multi-cycle ops (op[3]=1): 1000 SLL, 1001 SRL, 1010 SRA, all by b[SHW-1:0]; 1011 MUL, low WIDTH bits of unsigned a*b.
- Reserved ops 11xx: single-cycle, result 0, zero=1, all other flags 0.
- Flags for op[3]=0:
  - g = carry-out of a+b' with carry-in 0.
  - p = &(a|b').
  - Adder carry-out equals g|(p&ci).
  - overflow = signed overflow of a+b'+ci.
  - set = sign(a-b) xor overflow(a-b).
- Flags for op[3]=1: g=p=set=overflow=0. zero is valid for every op.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch a, b, op and ci. Single-cycle op -> DONE with result registered. Multi-cycle op -> BUSY, count loaded.
  - BUSY: in_ready=0. One step per cycle.
    - Shift: shift 1 bit, count = amount. Amount 0 -> direct to DONE.
    - SRA fills with the original a[WIDTH-1].
    - MUL: WIDTH steps. Each step, if b_reg[0] then acc += a_reg; then a_reg<<=1, b_reg>>=1. Wraps mod 2^WIDTH.
    - At count 0 -> DONE.
  - DONE: out_valid=1. result and flags held stable until out_ready.
    - out_ready=1 and in_valid=1: accept the new op in the same cycle (next state as from IDLE).
    - Otherwise -> IDLE on out_ready.
  - in_ready = IDLE | (DONE & out_ready).
- Latency, accept at edge T:
  - Single-cycle op: out_valid at T+1. Full throughput with out_ready held 1.
  - Shift by k: out_valid at T+1+k.
  - MUL: out_valid at T+1+WIDTH.
- Inputs are sampled only at acceptance; later changes to a/b/op have no effect.
- Reset (asynchronous, any state, including mid-BUSY): state=IDLE, result=0, all flags 0, out_valid=0, counters and latches 0. in_ready follows IDLE (1); no transfer completes while rst_n=0.
- No X on outputs after reset.

Test Plan:
- WIDTH=8. a=0x01, b=0x01, op=0101 -> at T+1: result 0xFF, zero=0, g=0, p=1, out_valid=1.
- SUB and SLT: a=0x05, b=0x07, op=0110 -> result 0xFE, g=0, set=1, overflow=0. Then op=0111 -> result 0x01, issued back-to-back with no bubble.
- ADD: a=0x7F, b=0x01, cin=0 -> result 0x80, overflow=1, g=0. Then a=0xFF, b=0x01, cin=0 -> result 0x00, zero=1, g=1. Then a=0x00, b=0x00, cin=1 -> result 0x01.
- MUL: a=13, b=11, op=1011 accepted at T -> in_ready=0 for T+1..T+8; result 0x8F and out_valid at T+9. Also a=0xFF, b=0xFF -> 0x01 (wrap).
- SRA: a=0x90, b=3, op=1010 -> 0xF2 at T+4. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; accepted on the out_ready=1 cycle. SLL with b=0 -> T+1.
- Reset: assert rst_n=0 at T+4 of a MUL -> out_valid=0 and result=0 immediately. After release, in_ready=1, and ADD 0x03+0x04 -> 0x07 at the next T+1.
